// File: rtl/cc_bank_req_ctrl.sv
`timescale 1ns/1ps
// cc_bank_req_ctrl
//   Request controller in front of one single-port cache-bank SRAM macro
//   (1-cycle synchronous read, no write mask). Accepts reads/writes over
//   valid/ready and drives the SRAM port. Byte-masked writes are done as a
//   read-modify-write. Read data comes back through a 2-entry fall-through
//   response FIFO with full backpressure.
//
//   Ports:
//     clock, reset_n            clock (shared with SRAM), async active-low reset
//     req_valid/req_ready       request handshake
//     req_write/addr/wdata/mask request fields (mask used by writes only)
//     resp_valid/ready/rdata    read response stream, in request order
//     sram_addr/en/wmode/wdata  SRAM RW0 port drive (combinational)
//     sram_rdata                SRAM RW0 read data, valid the cycle after a read
//     perf_reads/writes/rmw     32b wrapping event counters (CC_BANK_PERF_EN only)
//
//   Build option: define CC_BANK_PERF_EN to add the perf_* counters and ports.
module cc_bank_req_ctrl #(
  parameter  int unsigned ADDR_W = 14,
  parameter  int unsigned DATA_W = 64,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
`ifdef CC_BANK_PERF_EN
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_rmw,
`endif
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic              rd_inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              head_q;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              accept, acc_read, acc_full, acc_part;
  logic              push, pop;
  logic [1:0]        credits_used;
  logic [DATA_W-1:0] bytemask;

  // An in-flight read holds a FIFO slot, so a push can never find the FIFO full.
  assign credits_used = fifo_cnt_q + {1'b0, rd_inflight_q};
  assign req_ready    = reset_n && (state_q == IDLE) && (credits_used < 2'd2);

  assign accept   = req_valid && req_ready;
  assign acc_read = accept && !req_write;
  assign acc_full = accept && req_write && (req_mask == '1);
  assign acc_part = accept && req_write && (req_mask != '1) && (req_mask != '0);

  always_comb begin
    bytemask = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      bytemask[i*8 +: 8] = {8{mask_q[i]}};
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    state_d    = state_q;
    if (state_q == RMW_WR) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = addr_q;
      sram_wdata = (sram_rdata & ~bytemask) | (wdata_q & bytemask);
      state_d    = IDLE;
    end else if (acc_read || acc_part) begin
      sram_en   = 1'b1;
      sram_addr = req_addr;
      if (acc_part) state_d = RMW_WR;
    end else if (acc_full) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = req_addr;
      sram_wdata = req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc_part) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
      end
    end
  end

  // Fall-through FIFO: the returning SRAM word is visible at the head in the
  // same cycle it is pushed; if popped straight away it is never stored.
  assign push       = rd_inflight_q;
  assign resp_valid = (fifo_cnt_q != 2'd0) || push;
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = (fifo_cnt_q != 2'd0) ? fifo_q[head_q] :
                      (push ? sram_rdata : '0);
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_inflight_q <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      head_q        <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      rd_inflight_q <= acc_read;
      if (push && !(pop && fifo_cnt_q == 2'd0)) begin
        fifo_q[head_q ^ fifo_cnt_q[0]] <= sram_rdata;
      end
      if (pop && fifo_cnt_q != 2'd0) head_q <= ~head_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

`ifdef CC_BANK_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q, perf_rmw_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_rmw_q    <= '0;
    end else begin
      if (acc_read)             perf_reads_q  <= perf_reads_q + 32'd1;
      if (acc_full || acc_part) perf_writes_q <= perf_writes_q + 32'd1;
      if (acc_part)             perf_rmw_q    <= perf_rmw_q + 32'd1;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
  assign perf_rmw    = perf_rmw_q;
`endif

endmodule

// File: tb/tb_cc_bank_req_ctrl.sv
`timescale 1ns/1ps
module tb_cc_bank_req_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [13:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_mask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [13:0] sram_addr;
  logic        sram_en, sram_wmode;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata = '0;
`ifdef CC_BANK_PERF_EN
  logic [31:0] perf_reads, perf_writes, perf_rmw;
`endif

  always #5 clock = ~clock;

  cc_bank_req_ctrl #(.ADDR_W(14), .DATA_W(64)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wdata (sram_wdata),
`ifdef CC_BANK_PERF_EN
    .perf_reads (perf_reads),
    .perf_writes(perf_writes),
    .perf_rmw   (perf_rmw),
`endif
    .sram_rdata (sram_rdata)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned sram_wr_cnt = 0;
  int unsigned sram_en_cnt = 0;
  int unsigned resp_cnt = 0;
  int unsigned exp_reads = 0, exp_writes = 0, exp_rmw = 0;
  logic [63:0] exp_q [$];
  logic [63:0] sram_mem [logic [13:0]];
  logic [63:0] ref_mem  [logic [13:0]];

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [13:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  // Behavioural SRAM: 1-cycle synchronous read, whole-word write.
  always @(posedge clock) begin
    if (sram_en === 1'b1) begin
      sram_en_cnt++;
      if (sram_wmode) begin
        sram_mem[sram_addr] = sram_wdata;
        sram_wr_cnt++;
      end else begin
        sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 64'd0;
      end
    end
  end

  // Scoreboard consumer: compare every popped response with the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      resp_cnt++;
      if (exp_q.size() == 0) chk_val("resp_pending", 64'(exp_q.size()), 64'd1);
      else                   chk_val("resp_data", resp_rdata, exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic w, input logic [13:0] a, input logic [63:0] d,
                      input logic [7:0] m);
    int unsigned n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_mask = m;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (!req_ready) begin
      chk_val("accept_timeout", 64'(req_ready), 64'd1);
    end else if (!w) begin
      exp_q.push_back(ref_rd(a));
      exp_reads++;
    end else if (m != 8'h00) begin
      ref_mem[a] = (ref_rd(a) & ~expand(m)) | (d & expand(m));
      exp_writes++;
      if (m != 8'hFF) exp_rmw++;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clock); #1;
    end
    chk_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, e0, r0;
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_mask = '0; resp_ready = 1'b1;

    // Reset state, with a request already offered
    repeat (3) @(posedge clock);
    #1;
    chk_val("rst_req_ready", 64'(req_ready), 64'd0);
    chk_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk_val("rst_sram_en", 64'(sram_en), 64'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    chk_val("ready_after_reset", 64'(req_ready), 64'd1);
    @(posedge clock); #1;

    // Full write then read-back with 1-cycle latency
    w0 = sram_wr_cnt;
    send(1'b1, 14'h0010, 64'h0123456789ABCDEF, 8'hFF);
    chk_val("full_wr_count", 64'(sram_wr_cnt - w0), 64'd1);
    send(1'b0, 14'h0010, '0, '0);
    chk_val("rd_latency_valid", 64'(resp_valid), 64'd1);
    chk_val("rd_latency_data", resp_rdata, 64'h0123456789ABCDEF);
    @(posedge clock); #1;
    chk_val("resp_empty", 64'(resp_valid), 64'd0);
    chk_val("resp_empty_data", resp_rdata, 64'd0);

    // Partial write: RMW_WR cycle merges low 4 bytes over the old word
    send(1'b1, 14'h0010, 64'hFFFFFFFF_00000000, 8'h0F);
    chk_val("rmw_ready", 64'(req_ready), 64'd0);
    chk_val("rmw_en", 64'(sram_en), 64'd1);
    chk_val("rmw_wmode", 64'(sram_wmode), 64'd1);
    chk_val("rmw_addr", 64'(sram_addr), 64'h10);
    chk_val("rmw_wdata", sram_wdata, 64'h01234567_00000000);
    @(posedge clock); #1;
    chk_val("rmw_ready_back", 64'(req_ready), 64'd1);
    send(1'b0, 14'h0010, '0, '0);
    wait_drain();

    // Backpressure: only two reads fit while the consumer stalls
    for (int i = 0; i < 4; i++) send(1'b1, 14'h0100 + 14'(i), 64'hA5A5_0000_0000_0000 | 64'(i * 7 + 1), 8'hFF);
    resp_ready = 1'b0;
    r0 = resp_cnt;
    send(1'b0, 14'h0100, '0, '0);
    send(1'b0, 14'h0101, '0, '0);
    chk_val("bp_ready_now", 64'(req_ready), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    chk_val("bp_ready_held", 64'(req_ready), 64'd0);
    chk_val("bp_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    send(1'b0, 14'h0102, '0, '0);
    send(1'b0, 14'h0103, '0, '0);
    wait_drain();
    chk_val("bp_resp_count", 64'(resp_cnt - r0), 64'd4);

    // Zero-mask write makes no SRAM access; top address works
    send(1'b1, 14'h3FFF, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    e0 = sram_en_cnt;
    send(1'b1, 14'h3FFF, 64'h1111_2222_3333_4444, 8'h00);
    chk_val("mask0_no_access", 64'(sram_en_cnt - e0), 64'd0);
    chk_val("mask0_ready", 64'(req_ready), 64'd1);
    send(1'b0, 14'h3FFF, '0, '0);
    send(1'b1, 14'h3FFF, 64'h7700_0000_0000_0000, 8'h80);
    @(posedge clock); #1;
    send(1'b0, 14'h3FFF, '0, '0);
    wait_drain();

`ifdef CC_BANK_PERF_EN
    chk_val("perf_reads", 64'(perf_reads), 64'(exp_reads));
    chk_val("perf_writes", 64'(perf_writes), 64'(exp_writes));
    chk_val("perf_rmw", 64'(perf_rmw), 64'(exp_rmw));
`endif

    // Reset asserted during RMW_WR
    send(1'b1, 14'h0020, 64'h5555_5555_5555_5555, 8'h3C);
    chk_val("pre_rst_rmw_en", 64'(sram_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_val("rst_rmw_en", 64'(sram_en), 64'd0);
    chk_val("rst_rmw_ready", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    ref_mem.delete(14'h0020);
    exp_reads = 0; exp_writes = 0; exp_rmw = 0;
    @(posedge clock); #1;

    // Reset asserted with two FIFO entries held
    resp_ready = 1'b0;
    send(1'b0, 14'h0100, '0, '0);
    send(1'b0, 14'h0101, '0, '0);
    @(posedge clock); #1;
    chk_val("full_fifo_valid", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_val("rst_fifo_valid", 64'(resp_valid), 64'd0);
    chk_val("rst_fifo_data", resp_rdata, 64'd0);
    chk_val("rst_fifo_en", 64'(sram_en), 64'd0);
`ifdef CC_BANK_PERF_EN
    chk_val("rst_perf_reads", 64'(perf_reads), 64'd0);
    chk_val("rst_perf_writes", 64'(perf_writes), 64'd0);
    chk_val("rst_perf_rmw", 64'(perf_rmw), 64'd0);
`endif
    exp_q.delete();
    @(posedge clock); #1;
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    r0 = resp_cnt;
    send(1'b0, 14'h0101, '0, '0);
    wait_drain();
    chk_val("post_rst_resp_count", 64'(resp_cnt - r0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
